// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg -- shared types and constants for alu_instr_sequencer.
//
// Contents:
//   state_t        control-step states IDLE, T0..T6, HALT
//   OP_*           5-bit opcode encodings of the register-register ALU ops
//   IR_W, IR_MSB   instruction word geometry (opcode sits at the top)
//   strobes_t      bundle of the single-bit datapath strobes
//   fetch_strobes  strobe pattern of T0, reused wherever an instruction starts
// ---------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      T0,
      T1,
      T2,
      T3,
      T4,
      T5,
      T6,
      HALT
   } state_t;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_SHR = 5'b00111;
   localparam logic [4:0] OP_SHL = 5'b01000;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   localparam int IR_W   = 32;
   localparam int IR_MSB = IR_W - 1;

   typedef struct packed {
      logic pc_out;
      logic zlow_out;
      logic zhigh_out;
      logic mdr_out;
      logic mar_in;
      logic pc_in;
      logic mdr_in;
      logic ir_in;
      logic y_in;
      logic z_in;
      logic lo_in;
      logic hi_in;
      logic inc_pc;
      logic read;
   } strobes_t;

   // T0: PC onto the bus into MAR, and PC+1 into Z in the same cycle.
   function automatic strobes_t fetch_strobes();
      strobes_t s;
      s        = '0;
      s.pc_out = 1'b1;
      s.mar_in = 1'b1;
      s.inc_pc = 1'b1;
      s.z_in   = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec -- register index to one-hot select vector.
//
// Ports:
//   idx     in   IDX_W  register index
//   onehot  out  N      one-hot select, all zero when idx is out of range
//   oor     out  1      idx >= N
// ---------------------------------------------------------------------------
module onehot_dec #(
   parameter int IDX_W = 4,
   parameter int N     = 16
) (
   input  logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot,
   output logic             oor
);

   logic [31:0] idx_w;

   always_comb begin
      idx_w = 32'(idx);
      oor   = (idx_w >= 32'(N));
      for (int i = 0; i < N; i++) begin
         onehot[i] = (idx_w == 32'(i));
      end
   end

endmodule

// File: rtl/alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer -- control-step sequencer for the single-bus datapath.
// Fetches an instruction, decodes register-register ALU formats and walks
// T0..T6, issuing bus-drive / register-load strobes and the ALU op code.
//
// Optional feature macro: SEQ_MULDIV_EN
//   defined   : MUL/DIV decoded; T4 waits for alu_done, T5 writes LO, T6 HI.
//   undefined : MUL/DIV are illegal opcodes; no alu_done wait, no T6.
//
// Ports:
//   clk        in   1         rising-edge clock
//   clr        in   1         asynchronous active-low reset
//   run        in   1         start / continue execution
//   ir         in   32        current IR contents
//   mem_rdy    in   1         memory read data valid (looked at in T1 only)
//   alu_done   in   1         multi-cycle ALU result ready (T4 only)
//   pc_out, zlow_out, zhigh_out, mdr_out                  out  bus drives
//   mar_in, pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in out  loads
//   inc_pc, read  out  1      PC increment, memory read
//   alu_op     out  OPCODE_W  ALU operation, meaningful while z_in=1
//   reg_in     out  NUM_REGS  one-hot GPR load
//   reg_out    out  NUM_REGS  one-hot GPR bus drive
//   busy       out  1         high outside IDLE
//   illegal    out  1         sticky illegal-instruction flag
//
// All outputs are registered: the strobes for a state are computed on the
// edge that enters it. The T3 decision is therefore taken on the T2->T3
// edge from ir, which must carry the fetched word by the end of T2.
// ---------------------------------------------------------------------------
module alu_instr_sequencer
   import seq_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int OPCODE_W  = 5,
   parameter int REG_IDX_W = 4
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                run,
   input  logic [31:0]         ir,
   input  logic                mem_rdy,
   input  logic                alu_done,
   output logic                pc_out,
   output logic                zlow_out,
   output logic                zhigh_out,
   output logic                mdr_out,
   output logic                mar_in,
   output logic                pc_in,
   output logic                mdr_in,
   output logic                ir_in,
   output logic                y_in,
   output logic                z_in,
   output logic                lo_in,
   output logic                hi_in,
   output logic                inc_pc,
   output logic                read,
   output logic [OPCODE_W-1:0] alu_op,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [NUM_REGS-1:0] reg_out,
   output logic                busy,
   output logic                illegal
);

   localparam int RA_MSB = IR_MSB - OPCODE_W;
   localparam int RB_MSB = RA_MSB - REG_IDX_W;
   localparam int RC_MSB = RB_MSB - REG_IDX_W;
   localparam int RC_LSB = RC_MSB - REG_IDX_W + 1;

   // Instruction fields
   logic [OPCODE_W-1:0]  op;
   logic [NUM_REGS-1:0]  ra_oh, rb_oh, rc_oh;
   logic                 ra_oor, rb_oor, rc_oor;
   logic                 is_single, is_md, bad;

   assign op = ir[IR_MSB -: OPCODE_W];

   onehot_dec #(.IDX_W(REG_IDX_W), .N(NUM_REGS)) u_ra_dec (
      .idx    (ir[RA_MSB -: REG_IDX_W]),
      .onehot (ra_oh),
      .oor    (ra_oor)
   );

   onehot_dec #(.IDX_W(REG_IDX_W), .N(NUM_REGS)) u_rb_dec (
      .idx    (ir[RB_MSB -: REG_IDX_W]),
      .onehot (rb_oh),
      .oor    (rb_oor)
   );

   onehot_dec #(.IDX_W(REG_IDX_W), .N(NUM_REGS)) u_rc_dec (
      .idx    (ir[RC_MSB -: REG_IDX_W]),
      .onehot (rc_oh),
      .oor    (rc_oor)
   );

   assign is_single = (op == OPCODE_W'(OP_ADD)) || (op == OPCODE_W'(OP_SUB)) ||
                      (op == OPCODE_W'(OP_AND)) || (op == OPCODE_W'(OP_OR))  ||
                      (op == OPCODE_W'(OP_SHL)) || (op == OPCODE_W'(OP_SHR));

   logic unused_bits;
`ifdef SEQ_MULDIV_EN
   assign is_md       = (op == OPCODE_W'(OP_MUL)) || (op == OPCODE_W'(OP_DIV));
   assign unused_bits = ^ir[RC_LSB-1:0];
`else
   assign is_md       = 1'b0;
   assign unused_bits = ^{alu_done, ir[RC_LSB-1:0]};
`endif

   assign bad = !(is_single || is_md) || ra_oor || rb_oor || rc_oor;

   // Next-state / next-output logic
   state_t              state, state_nx;
   strobes_t            stb, stb_nx;
   logic [OPCODE_W-1:0] alu_op_nx;
   logic [NUM_REGS-1:0] reg_in_nx, reg_out_nx;
   logic                busy_nx, illegal_nx;
`ifdef SEQ_MULDIV_EN
   logic                muldiv, muldiv_nx;
`endif

   always_comb begin
      state_nx   = state;
      stb_nx     = '0;
      alu_op_nx  = '0;
      reg_in_nx  = '0;
      reg_out_nx = '0;
      illegal_nx = illegal;
`ifdef SEQ_MULDIV_EN
      muldiv_nx  = muldiv;
`endif
      case (state)
         IDLE: begin
            if (run) begin
               state_nx = T0;
               stb_nx   = fetch_strobes();
            end
         end
         T0: begin
            state_nx        = T1;
            stb_nx.zlow_out = 1'b1;
            stb_nx.pc_in    = 1'b1;   // only on entry, so one pulse per fetch
            stb_nx.read     = 1'b1;
            stb_nx.mdr_in   = 1'b1;
         end
         T1: begin
            if (mem_rdy) begin
               state_nx       = T2;
               stb_nx.mdr_out = 1'b1;
               stb_nx.ir_in   = 1'b1;
            end else begin
               stb_nx.zlow_out = 1'b1;
               stb_nx.read     = 1'b1;
               stb_nx.mdr_in   = 1'b1;
            end
         end
         T2: begin
            state_nx = T3;
            if (bad) begin
               // T3 of a bad instruction drives nothing; HALT follows.
               illegal_nx = 1'b1;
            end else begin
               stb_nx.y_in = 1'b1;
               reg_out_nx  = rb_oh;
`ifdef SEQ_MULDIV_EN
               muldiv_nx   = is_md;
`endif
            end
         end
         T3: begin
            if (illegal) begin
               state_nx = HALT;
            end else begin
               state_nx    = T4;
               stb_nx.z_in = 1'b1;
               reg_out_nx  = rc_oh;
               alu_op_nx   = op;
            end
         end
         T4: begin
`ifdef SEQ_MULDIV_EN
            if (muldiv && !alu_done) begin
               stb_nx.z_in = 1'b1;
               reg_out_nx  = rc_oh;
               alu_op_nx   = op;
            end else begin
               state_nx        = T5;
               stb_nx.zlow_out = 1'b1;
               if (muldiv) stb_nx.lo_in = 1'b1;
               else        reg_in_nx    = ra_oh;
            end
`else
            state_nx        = T5;
            stb_nx.zlow_out = 1'b1;
            reg_in_nx       = ra_oh;
`endif
         end
         T5: begin
`ifdef SEQ_MULDIV_EN
            if (muldiv) begin
               state_nx         = T6;
               stb_nx.zhigh_out = 1'b1;
               stb_nx.hi_in     = 1'b1;
            end else if (run) begin
               state_nx = T0;
               stb_nx   = fetch_strobes();
            end else begin
               state_nx = IDLE;
            end
`else
            if (run) begin
               state_nx = T0;
               stb_nx   = fetch_strobes();
            end else begin
               state_nx = IDLE;
            end
`endif
         end
`ifdef SEQ_MULDIV_EN
         T6: begin
            if (run) begin
               state_nx = T0;
               stb_nx   = fetch_strobes();
            end else begin
               state_nx = IDLE;
            end
         end
`endif
         HALT: begin
            state_nx = HALT;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= IDLE;
         stb     <= '0;
         alu_op  <= '0;
         reg_in  <= '0;
         reg_out <= '0;
         busy    <= 1'b0;
         illegal <= 1'b0;
`ifdef SEQ_MULDIV_EN
         muldiv  <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         stb     <= stb_nx;
         alu_op  <= alu_op_nx;
         reg_in  <= reg_in_nx;
         reg_out <= reg_out_nx;
         busy    <= busy_nx;
         illegal <= illegal_nx;
`ifdef SEQ_MULDIV_EN
         muldiv  <= muldiv_nx;
`endif
      end
   end

   assign pc_out    = stb.pc_out;
   assign zlow_out  = stb.zlow_out;
   assign zhigh_out = stb.zhigh_out;
   assign mdr_out   = stb.mdr_out;
   assign mar_in    = stb.mar_in;
   assign pc_in     = stb.pc_in;
   assign mdr_in    = stb.mdr_in;
   assign ir_in     = stb.ir_in;
   assign y_in      = stb.y_in;
   assign z_in      = stb.z_in;
   assign lo_in     = stb.lo_in;
   assign hi_in     = stb.hi_in;
   assign inc_pc    = stb.inc_pc;
   assign read      = stb.read;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_instr_sequencer -- directed bench for alu_instr_sequencer.
// A vector table covers AND followed back-to-back by ADD; hand-written
// sequences cover the T1 memory wait, MUL/DIV handling (SEQ_MULDIV_EN),
// the illegal-opcode halt and an asynchronous reset in the middle of T4.
// ---------------------------------------------------------------------------
module tb_alu_instr_sequencer;

   // Strobe bit positions in the bench's own packing
   localparam logic [13:0] S_PC_OUT    = 14'h2000;
   localparam logic [13:0] S_ZLOW_OUT  = 14'h1000;
   localparam logic [13:0] S_ZHIGH_OUT = 14'h0800;
   localparam logic [13:0] S_MDR_OUT   = 14'h0400;
   localparam logic [13:0] S_MAR_IN    = 14'h0200;
   localparam logic [13:0] S_PC_IN     = 14'h0100;
   localparam logic [13:0] S_MDR_IN    = 14'h0080;
   localparam logic [13:0] S_IR_IN     = 14'h0040;
   localparam logic [13:0] S_Y_IN      = 14'h0020;
   localparam logic [13:0] S_Z_IN      = 14'h0010;
   localparam logic [13:0] S_LO_IN     = 14'h0008;
   localparam logic [13:0] S_HI_IN     = 14'h0004;
   localparam logic [13:0] S_INC_PC    = 14'h0002;
   localparam logic [13:0] S_READ      = 14'h0001;

   localparam logic [13:0] E_T0  = S_PC_OUT | S_MAR_IN | S_INC_PC | S_Z_IN;
   localparam logic [13:0] E_T1A = S_ZLOW_OUT | S_PC_IN | S_READ | S_MDR_IN;
   localparam logic [13:0] E_T1B = S_ZLOW_OUT | S_READ | S_MDR_IN;
   localparam logic [13:0] E_T2  = S_MDR_OUT | S_IR_IN;
   localparam logic [13:0] E_T3  = S_Y_IN;
   localparam logic [13:0] E_T4  = S_Z_IN;
   localparam logic [13:0] E_T5  = S_ZLOW_OUT;
   localparam logic [13:0] E_T5M = S_ZLOW_OUT | S_LO_IN;
   localparam logic [13:0] E_T6  = S_ZHIGH_OUT | S_HI_IN;
   localparam logic [13:0] E_NO  = 14'h0000;

   localparam logic [31:0] I_AND = 32'h28918000; // AND R1,R2,R3
   localparam logic [31:0] I_SUB = 32'h20918000; // SUB R1,R2,R3
   localparam logic [31:0] I_ADD = 32'h1A2B0000; // ADD R4,R5,R6
   localparam logic [31:0] I_MUL = 32'h7BC48000; // MUL R7,R8,R9
   localparam logic [31:0] I_BAD = 32'hF8000000; // opcode 11111

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        run = 1'b0;
   logic [31:0] ir = 32'h0;
   logic        mem_rdy = 1'b0;
   logic        alu_done = 1'b0;
   logic        pc_out, zlow_out, zhigh_out, mdr_out;
   logic        mar_in, pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in;
   logic        inc_pc, read, busy, illegal;
   logic [4:0]  alu_op;
   logic [15:0] reg_in, reg_out;

   int checks = 0;
   int errors = 0;

   alu_instr_sequencer dut (
      .clk       (clk),
      .clr       (clr),
      .run       (run),
      .ir        (ir),
      .mem_rdy   (mem_rdy),
      .alu_done  (alu_done),
      .pc_out    (pc_out),
      .zlow_out  (zlow_out),
      .zhigh_out (zhigh_out),
      .mdr_out   (mdr_out),
      .mar_in    (mar_in),
      .pc_in     (pc_in),
      .mdr_in    (mdr_in),
      .ir_in     (ir_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .lo_in     (lo_in),
      .hi_in     (hi_in),
      .inc_pc    (inc_pc),
      .read      (read),
      .alu_op    (alu_op),
      .reg_in    (reg_in),
      .reg_out   (reg_out),
      .busy      (busy),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ir;
      logic        run;
      logic        mem;
      logic        done;
      logic [13:0] stb;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  op;
      logic        busy;
      logic        ill;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl[NV];

   task automatic set_vec(input int i, input logic [31:0] v_ir, input logic v_run,
                          input logic v_mem, input logic v_done, input logic [13:0] v_stb,
                          input logic [15:0] v_rin, input logic [15:0] v_rout,
                          input logic [4:0] v_op, input logic v_busy, input logic v_ill);
      tbl[i].ir   = v_ir;
      tbl[i].run  = v_run;
      tbl[i].mem  = v_mem;
      tbl[i].done = v_done;
      tbl[i].stb  = v_stb;
      tbl[i].rin  = v_rin;
      tbl[i].rout = v_rout;
      tbl[i].op   = v_op;
      tbl[i].busy = v_busy;
      tbl[i].ill  = v_ill;
   endtask

   task automatic check(input string nm, input logic [13:0] es, input logic [15:0] ri,
                        input logic [15:0] ro, input logic [4:0] op, input logic b,
                        input logic il);
      logic [13:0] as;
      as = {pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in,
            y_in, z_in, lo_in, hi_in, inc_pc, read};
      checks++;
      if (as !== es || reg_in !== ri || reg_out !== ro || alu_op !== op ||
          busy !== b || illegal !== il) begin
         errors++;
         $display("FAIL %s: got stb=%h reg_in=%h reg_out=%h alu_op=%h busy=%b illegal=%b, expected stb=%h reg_in=%h reg_out=%h alu_op=%h busy=%b illegal=%b",
                  nm, as, reg_in, reg_out, alu_op, busy, illegal, es, ri, ro, op, b, il);
      end
   endtask

   // Drive inputs for one cycle, then check the state entered on the edge.
   task automatic step(input string nm, input logic r, input logic m, input logic a,
                       input logic [13:0] es, input logic [15:0] ri, input logic [15:0] ro,
                       input logic [4:0] op, input logic b, input logic il);
      run      = r;
      mem_rdy  = m;
      alu_done = a;
      @(posedge clk);
      #1;
      check(nm, es, ri, ro, op, b, il);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      // AND R1,R2,R3 then, with run held, ADD R4,R5,R6 and drop to IDLE.
      // mem_rdy/alu_done held high where they must be ignored.
      set_vec(0,  I_AND, 1'b1, 1'b1, 1'b1, E_T0,  16'h0000, 16'h0000, 5'h00, 1'b1, 1'b0);
      set_vec(1,  I_AND, 1'b1, 1'b1, 1'b1, E_T1A, 16'h0000, 16'h0000, 5'h00, 1'b1, 1'b0);
      set_vec(2,  I_AND, 1'b1, 1'b1, 1'b1, E_T2,  16'h0000, 16'h0000, 5'h00, 1'b1, 1'b0);
      set_vec(3,  I_AND, 1'b1, 1'b1, 1'b1, E_T3,  16'h0000, 16'h0004, 5'h00, 1'b1, 1'b0);
      set_vec(4,  I_AND, 1'b1, 1'b1, 1'b1, E_T4,  16'h0000, 16'h0008, 5'h05, 1'b1, 1'b0);
      set_vec(5,  I_AND, 1'b1, 1'b1, 1'b1, E_T5,  16'h0002, 16'h0000, 5'h00, 1'b1, 1'b0);
      set_vec(6,  I_AND, 1'b1, 1'b1, 1'b1, E_T0,  16'h0000, 16'h0000, 5'h00, 1'b1, 1'b0);
      set_vec(7,  I_ADD, 1'b1, 1'b1, 1'b1, E_T1A, 16'h0000, 16'h0000, 5'h00, 1'b1, 1'b0);
      set_vec(8,  I_ADD, 1'b1, 1'b1, 1'b1, E_T2,  16'h0000, 16'h0000, 5'h00, 1'b1, 1'b0);
      set_vec(9,  I_ADD, 1'b1, 1'b1, 1'b1, E_T3,  16'h0000, 16'h0020, 5'h00, 1'b1, 1'b0);
      set_vec(10, I_ADD, 1'b0, 1'b1, 1'b1, E_T4,  16'h0000, 16'h0040, 5'h03, 1'b1, 1'b0);
      set_vec(11, I_ADD, 1'b0, 1'b1, 1'b1, E_T5,  16'h0010, 16'h0000, 5'h00, 1'b1, 1'b0);
      set_vec(12, I_ADD, 1'b0, 1'b1, 1'b1, E_NO,  16'h0000, 16'h0000, 5'h00, 1'b0, 1'b0);
      set_vec(13, I_ADD, 1'b0, 1'b1, 1'b1, E_NO,  16'h0000, 16'h0000, 5'h00, 1'b0, 1'b0);

      // Reset state, with clr low from time zero
      #1;
      check("reset", E_NO, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
      #11;
      clr = 1'b1;

      for (int i = 0; i < NV; i++) begin
         ir = tbl[i].ir;
         step($sformatf("vec%0d", i), tbl[i].run, tbl[i].mem, tbl[i].done,
              tbl[i].stb, tbl[i].rin, tbl[i].rout, tbl[i].op, tbl[i].busy, tbl[i].ill);
      end

      // SUB with memory three cycles late: T1 for four cycles, pc_in once
      ir = I_SUB;
      step("sub_t0",   1'b1, 1'b0, 1'b0, E_T0,  16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("sub_t1_1", 1'b0, 1'b0, 1'b0, E_T1A, 16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("sub_t1_2", 1'b0, 1'b0, 1'b0, E_T1B, 16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("sub_t1_3", 1'b0, 1'b0, 1'b0, E_T1B, 16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("sub_t1_4", 1'b0, 1'b0, 1'b0, E_T1B, 16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("sub_t2",   1'b0, 1'b1, 1'b0, E_T2,  16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("sub_t3",   1'b0, 1'b0, 1'b0, E_T3,  16'h0, 16'h0004, 5'h00, 1'b1, 1'b0);
      step("sub_t4",   1'b0, 1'b0, 1'b0, E_T4,  16'h0, 16'h0008, 5'h04, 1'b1, 1'b0);
      step("sub_t5",   1'b0, 1'b0, 1'b0, E_T5,  16'h0002, 16'h0, 5'h00, 1'b1, 1'b0);
      step("sub_idle", 1'b0, 1'b0, 1'b0, E_NO,  16'h0, 16'h0,    5'h00, 1'b0, 1'b0);

      ir = I_MUL;
`ifdef SEQ_MULDIV_EN
      // MUL R7,R8,R9: T4 held six cycles until alu_done, then LO and HI writes
      step("mul_t0",  1'b1, 1'b1, 1'b0, E_T0,  16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("mul_t1",  1'b0, 1'b1, 1'b0, E_T1A, 16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("mul_t2",  1'b0, 1'b1, 1'b0, E_T2,  16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("mul_t3",  1'b0, 1'b1, 1'b1, E_T3,  16'h0, 16'h0100, 5'h00, 1'b1, 1'b0);
      step("mul_t4_1", 1'b0, 1'b1, 1'b1, E_T4, 16'h0, 16'h0200, 5'h0F, 1'b1, 1'b0);
      for (int k = 2; k <= 6; k++) begin
         step($sformatf("mul_t4_%0d", k), 1'b0, 1'b1, 1'b0, E_T4, 16'h0, 16'h0200,
              5'h0F, 1'b1, 1'b0);
      end
      step("mul_t5",   1'b0, 1'b1, 1'b1, E_T5M, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
      step("mul_t6",   1'b0, 1'b1, 1'b0, E_T6,  16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
      step("mul_idle", 1'b0, 1'b1, 1'b0, E_NO,  16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
`else
      // Without the MUL/DIV option, MUL is an illegal opcode
      step("mul_t0",   1'b1, 1'b1, 1'b0, E_T0,  16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
      step("mul_t1",   1'b0, 1'b1, 1'b0, E_T1A, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
      step("mul_t2",   1'b0, 1'b1, 1'b0, E_T2,  16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
      step("mul_ill",  1'b0, 1'b1, 1'b1, E_NO,  16'h0, 16'h0, 5'h00, 1'b1, 1'b1);
      step("mul_halt", 1'b1, 1'b1, 1'b1, E_NO,  16'h0, 16'h0, 5'h00, 1'b1, 1'b1);
      #2 clr = 1'b0;
      #1 check("mul_clr", E_NO, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
      #1 clr = 1'b1;
      step("mul_idle", 1'b0, 1'b0, 1'b0, E_NO, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
`endif

      // Opcode 11111: flag in T3, HALT with all strobes low until clr
      ir = I_BAD;
      step("bad_t0",  1'b1, 1'b1, 1'b0, E_T0,  16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
      step("bad_t1",  1'b1, 1'b1, 1'b0, E_T1A, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
      step("bad_t2",  1'b1, 1'b1, 1'b0, E_T2,  16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
      step("bad_t3",  1'b1, 1'b1, 1'b0, E_NO,  16'h0, 16'h0, 5'h00, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step($sformatf("bad_halt%0d", k), 1'b1, 1'b1, 1'b1, E_NO, 16'h0, 16'h0,
              5'h00, 1'b1, 1'b1);
      end
      #2 clr = 1'b0;
      #1 check("bad_clr", E_NO, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
      #1 clr = 1'b1;
      step("bad_idle", 1'b0, 1'b0, 1'b0, E_NO, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);

      // clr mid-T4: outputs drop without waiting for a clock edge
      ir = I_AND;
      step("rst_t0", 1'b1, 1'b1, 1'b0, E_T0,  16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("rst_t1", 1'b0, 1'b1, 1'b0, E_T1A, 16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("rst_t2", 1'b0, 1'b1, 1'b0, E_T2,  16'h0, 16'h0,    5'h00, 1'b1, 1'b0);
      step("rst_t3", 1'b0, 1'b1, 1'b0, E_T3,  16'h0, 16'h0004, 5'h00, 1'b1, 1'b0);
      step("rst_t4", 1'b0, 1'b1, 1'b0, E_T4,  16'h0, 16'h0008, 5'h05, 1'b1, 1'b0);
      #3 clr = 1'b0;
      #1 check("rst_async", E_NO, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
      #1 clr = 1'b1;
      step("rst_idle", 1'b0, 1'b1, 1'b0, E_NO, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
